fft_butterfly: RTL and testbench
================================

// Module: fft_butterfly
// PURPOSE
//  Radix-2 decimation-in-time FFT butterfly on 16-bit signed complex samples.
//  Computes Xa = (xa + W*xb)/2 and Xb = (xa - W*xb)/2, with the twiddle W in Q1.15.
//  The 1/2 scaling per stage prevents bit growth across FFT stages.
//  It is the arithmetic core instanced by each stage of the FFT datapath.
// PARAMETERS
//  DW  16  sample/twiddle width (two's complement); all widths below derive from DW
//  FB  15  twiddle fractional bits (Q1.15); product rounding shift
// PORTS
//  clk     in   1   rising-edge clock, single clock domain
//  rst_n   in   1   synchronous reset, active low
//  enable  in   1   pipeline clock-enable; 0 = all registers hold
//  xa_re   in   16  upper input, real, signed
//  xa_im   in   16  upper input, imag, signed
//  xb_re   in   16  lower input, real, signed
//  xb_im   in   16  lower input, imag, signed
//  W_re    in   16  twiddle real, signed Q1.15
//  W_im    in   16  twiddle imag, signed Q1.15
//  Xa_re   out  16  (xa + W*xb)/2 real, registered
//  Xa_im   out  16  (xa + W*xb)/2 imag, registered
//  Xb_re   out  16  (xa - W*xb)/2 real, registered
//  Xb_im   out  16  (xa - W*xb)/2 imag, registered
// BEHAVIOUR
//  - Reset: if rst_n==0 at a clk edge, all pipeline and output registers clear to 0.
//    Reset has priority over enable and can be applied mid-stream; in-flight data is discarded.
//  - Stage 1 (enable=1): register the four 32-bit products xb_re*W_re, xb_im*W_im,
//    xb_re*W_im and xb_im*W_re, plus xa_re/xa_im delayed by one stage.
//  - Stage 2 (enable=1):
//    - pr = P(re*re) - P(im*im); pi = P(re*im) + P(im*re), both 33-bit signed.
//    - tr = (pr + 2^14) >>> 15 and ti likewise (round half up), 18-bit.
//    - sa = xa + t and sb = xa - t per component, 19-bit.
//    - Scale: (s + 1) >>> 1 (round half up).
//    - Saturate to [-32768, 32767]; then register to the outputs.
//  - Latency: 2 enabled clock edges from input to output. Throughput: 1 butterfly per enabled cycle.
//  - enable=0: every register, outputs included, holds its value. The pipeline advances only on enabled edges.
//  - Inputs are sampled only on enabled edges. No handshake and no valid flag; the upstream controller tracks latency.
//  - Boundaries: W=-32768 is legal (-1.0); +1.0 is not representable, so 32767 is used.
//  - Saturation occurs only in the full-scale corners; it must never wrap.
// STRUCTURE
//  - Shared package fft_pkg: DW, FB, the rounding constant 2^(FB-1), SAT_MAX=32767, SAT_MIN=-32768.
//  - Sub-module cmul_q15: the complex multiply, i.e. the stage-1 products plus the combine/round.
//    The butterfly instances cmul_q15 and adds the add/sub, scale and saturate logic.
//  - Multipliers are written as plain signed '*' so the tools can infer DSP blocks.
// TESTING
//  1. xa=(2,1), xb=(3,0), W=(32767,0) -> 2 enabled edges later: Xa=(3,1), Xb=(0,1).
//  2. xa=(2,1), xb=(3,0), W=(2,0) -> W*xb rounds to 0: Xa=(1,1), Xb=(1,1).
//  3. xa=(0,0), xb=(100,0), W=(0,-32768) (i.e. -j) -> Xa=(0,-50), Xb=(0,50).
//  4. xa=(32767,0), xb=(-32768,0), W=(-32768,0) -> Xa=(32767,0) (saturated), Xb=(0,0).
//  5. Stream vectors 1,2,3 on consecutive cycles, then drop enable for 3 cycles.
//     -> outputs are vector 1 then 2; they freeze during enable=0 and resume with vector 3.
//  6. Assert rst_n=0 for 1 cycle mid-stream -> all outputs read 0 after that edge.
//     The next 2 enabled edges output 0; post-reset inputs appear afterwards.
//  Also run a random bench against a bit-accurate model (at least 10k vectors, including full-scale corners).

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, rounding constants and saturation helper for the FFT butterfly
package fft_pkg;

    // Sample / twiddle width and twiddle fractional bits (Q1.15)
    localparam int DW  = 16;
    localparam int FB  = 15;

    // Derived widths: product, combined product, rounded twiddle product, add/sub sum
    localparam int PW  = 2 * DW;
    localparam int SW  = PW + 1;
    localparam int TW  = SW - FB;
    localparam int SAW = TW + 1;

    // Half-LSB constant added before the product shift (round half up)
    localparam int RND = 1 << (FB - 1);

    localparam logic signed [DW-1:0] SAT_MAX = DW'(32767);
    localparam logic signed [DW-1:0] SAT_MIN = DW'(-32768);

    typedef logic signed [DW-1:0]  sample_t;
    typedef logic signed [PW-1:0]  prod_t;
    typedef logic signed [SW-1:0]  sum_t;
    typedef logic signed [TW-1:0]  twp_t;
    typedef logic signed [SAW-1:0] bsum_t;

    // Halve with round-half-up, then clamp to the sample range so full-scale
    // corners pin to the rails instead of wrapping.
    function automatic sample_t scale_sat(input bsum_t s);
        bsum_t h;
        sample_t r;
        h = (s + SAW'(1)) >>> 1;
        if (h > SAW'(SAT_MAX)) begin
            r = SAT_MAX;
        end else if (h < SAW'(SAT_MIN)) begin
            r = SAT_MIN;
        end else begin
            r = DW'(h);
        end
        return r;
    endfunction

endpackage

// File: rtl/cmul_q15.sv
// rtl/cmul_q15.sv - registered complex multiply by a Q1.15 twiddle with round-half-up
module cmul_q15
    import fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DW-1:0]    b_re,
    input  logic [DW-1:0]    b_im,
    input  logic [DW-1:0]    w_re,
    input  logic [DW-1:0]    w_im,
    output logic [TW-1:0]    t_re,
    output logic [TW-1:0]    t_im
);

    localparam sum_t RND_S = SW'(RND);

    sample_t b_re_s, b_im_s, w_re_s, w_im_s;
    prod_t   p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    prod_t   p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    sum_t    pr, pi, pr_rnd, pi_rnd;

    assign b_re_s = sample_t'(b_re);
    assign b_im_s = sample_t'(b_im);
    assign w_re_s = sample_t'(w_re);
    assign w_im_s = sample_t'(w_im);

    // Stage-1 next state: the four partial products, held while enable is low
    always_comb begin
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ri_d = p_ri_q;
        p_ir_d = p_ir_q;
        if (enable) begin
            p_rr_d = b_re_s * w_re_s;
            p_ii_d = b_im_s * w_im_s;
            p_ri_d = b_re_s * w_im_s;
            p_ir_d = b_im_s * w_re_s;
        end
    end

    // Stage-1 product registers with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
        end else begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
        end
    end

    // Combine partial products one bit wider (only -1*-1 twice needs it), then round back to Q0
    always_comb begin
        pr     = SW'(p_rr_q) - SW'(p_ii_q);
        pi     = SW'(p_ri_q) + SW'(p_ir_q);
        pr_rnd = pr + RND_S;
        pi_rnd = pi + RND_S;
        t_re   = TW'(pr_rnd >>> FB);
        t_im   = TW'(pi_rnd >>> FB);
    end

endmodule

// File: rtl/fft_butterfly.sv
// rtl/fft_butterfly.sv - radix-2 DIT butterfly, two-stage pipeline with 1/2 scaling and saturation
module fft_butterfly
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [15:0]     xa_re,
    input  logic [15:0]     xa_im,
    input  logic [15:0]     xb_re,
    input  logic [15:0]     xb_im,
    input  logic [15:0]     W_re,
    input  logic [15:0]     W_im,
    output logic [15:0]     Xa_re,
    output logic [15:0]     Xa_im,
    output logic [15:0]     Xb_re,
    output logic [15:0]     Xb_im
);

    logic [TW-1:0] t_re, t_im;

    sample_t xa_re_d, xa_im_d, xa_re_q, xa_im_q;
    sample_t xa_out_re_d, xa_out_im_d, xb_out_re_d, xb_out_im_d;
    sample_t xa_out_re_q, xa_out_im_q, xb_out_re_q, xb_out_im_q;
    bsum_t   sa_re, sa_im, sb_re, sb_im;

    cmul_q15 u_cmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .b_re   (xb_re),
        .b_im   (xb_im),
        .w_re   (W_re),
        .w_im   (W_im),
        .t_re   (t_re),
        .t_im   (t_im)
    );

    // Stage-1 next state: delay xa so it lines up with the registered products
    always_comb begin
        xa_re_d = xa_re_q;
        xa_im_d = xa_im_q;
        if (enable) begin
            xa_re_d = sample_t'(xa_re);
            xa_im_d = sample_t'(xa_im);
        end
    end

    // Stage-2 next state: add/sub against the rounded product, halve, clamp
    always_comb begin
        sa_re = SAW'(xa_re_q) + SAW'(twp_t'(t_re));
        sa_im = SAW'(xa_im_q) + SAW'(twp_t'(t_im));
        sb_re = SAW'(xa_re_q) - SAW'(twp_t'(t_re));
        sb_im = SAW'(xa_im_q) - SAW'(twp_t'(t_im));
        xa_out_re_d = xa_out_re_q;
        xa_out_im_d = xa_out_im_q;
        xb_out_re_d = xb_out_re_q;
        xb_out_im_d = xb_out_im_q;
        if (enable) begin
            xa_out_re_d = scale_sat(sa_re);
            xa_out_im_d = scale_sat(sa_im);
            xb_out_re_d = scale_sat(sb_re);
            xb_out_im_d = scale_sat(sb_im);
        end
    end

    // Delayed-xa and output registers; reset wins over enable and drops in-flight data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xa_re_q     <= '0;
            xa_im_q     <= '0;
            xa_out_re_q <= '0;
            xa_out_im_q <= '0;
            xb_out_re_q <= '0;
            xb_out_im_q <= '0;
        end else begin
            xa_re_q     <= xa_re_d;
            xa_im_q     <= xa_im_d;
            xa_out_re_q <= xa_out_re_d;
            xa_out_im_q <= xa_out_im_d;
            xb_out_re_q <= xb_out_re_d;
            xb_out_im_q <= xb_out_im_d;
        end
    end

    assign Xa_re = xa_out_re_q;
    assign Xa_im = xa_out_im_q;
    assign Xb_re = xb_out_re_q;
    assign Xb_im = xb_out_im_q;

endmodule

// File: tb/tb_fft_butterfly.sv
// tb/tb_fft_butterfly.sv - self-checking bench for fft_butterfly
module tb_fft_butterfly;

    typedef struct {
        logic signed [15:0] xar, xai, xbr, xbi, wr, wi;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [63:0] exp;
    } tv_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] xa_re = '0, xa_im = '0, xb_re = '0, xb_im = '0, W_re = '0, W_im = '0;
    logic [15:0] Xa_re, Xa_im, Xb_re, Xb_im;

    int passed = 0;
    int total  = 0;

    fft_butterfly dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .xa_re  (xa_re),
        .xa_im  (xa_im),
        .xb_re  (xb_re),
        .xb_im  (xb_im),
        .W_re   (W_re),
        .W_im   (W_im),
        .Xa_re  (Xa_re),
        .Xa_im  (Xa_im),
        .Xb_re  (Xb_re),
        .Xb_im  (Xb_im)
    );

    always #5 clk = ~clk;

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    function automatic logic [15:0] clamp(input longint s);
        if (s > 32767)  return 16'h7fff;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // Mathematical butterfly: Xa/Xb = (xa +/- round(W*xb)) / 2, rounded half up, saturated
    function automatic logic [63:0] model(input vec_t v);
        longint pr, pi, tr, ti;
        pr = longint'(v.xbr) * longint'(v.wr) - longint'(v.xbi) * longint'(v.wi);
        pi = longint'(v.xbr) * longint'(v.wi) + longint'(v.xbi) * longint'(v.wr);
        tr = fdiv(pr + 16384, 32768);
        ti = fdiv(pi + 16384, 32768);
        return {clamp(fdiv(longint'(v.xar) + tr + 1, 2)),
                clamp(fdiv(longint'(v.xai) + ti + 1, 2)),
                clamp(fdiv(longint'(v.xar) - tr + 1, 2)),
                clamp(fdiv(longint'(v.xai) - ti + 1, 2))};
    endfunction

    function automatic vec_t mkvec(input int a, input int b, input int c, input int d,
                                   input int e, input int f);
        vec_t v;
        v.xar = 16'(a); v.xai = 16'(b); v.xbr = 16'(c);
        v.xbi = 16'(d); v.wr  = 16'(e); v.wi  = 16'(f);
        return v;
    endfunction

    function automatic logic [63:0] mkexp(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7fff;
            2:       return 16'h0000;
            3:       return 16'hffff;
            4:       return 16'h8001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive(input vec_t v, input logic en);
        xa_re = v.xar; xa_im = v.xai; xb_re = v.xbr;
        xb_im = v.xbi; W_re = v.wr;   W_im = v.wi;
        enable = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] exp);
        logic [63:0] got;
        got = {Xa_re, Xa_im, Xb_re, Xb_im};
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    tv_t  tbl [4];
    vec_t zero_v, v, s1;
    logic [63:0] o_exp;
    logic en;

    initial begin
        tbl[0].v = mkvec(2, 1, 3, 0, 32767, 0);       tbl[0].exp = mkexp(3, 1, 0, 1);
        tbl[1].v = mkvec(2, 1, 3, 0, 2, 0);           tbl[1].exp = mkexp(1, 1, 1, 1);
        tbl[2].v = mkvec(0, 0, 100, 0, 0, -32768);    tbl[2].exp = mkexp(0, -50, 0, 50);
        tbl[3].v = mkvec(32767, 0, -32768, 0, -32768, 0); tbl[3].exp = mkexp(32767, 0, 0, 0);
        zero_v = mkvec(0, 0, 0, 0, 0, 0);

        // Reset state, with nonzero inputs applied during reset
        rst_n = 1'b0;
        drive(tbl[0].v, 1'b1);
        step();
        step();
        chk("reset_state", 64'h0);
        rst_n = 1'b1;

        // Directed vectors: hold each input for two enabled edges
        for (int i = 0; i < 4; i++) begin
            drive(tbl[i].v, 1'b1);
            step();
            step();
            chk($sformatf("vec%0d", i + 1), tbl[i].exp);
        end

        // Streaming with an enable gap
        drive(tbl[0].v, 1'b1); step();
        drive(tbl[1].v, 1'b1); step();
        chk("stream_v1", tbl[0].exp);
        drive(tbl[2].v, 1'b1); step();
        chk("stream_v2", tbl[1].exp);
        for (int i = 0; i < 3; i++) begin
            drive(tbl[3].v, 1'b0);
            step();
            chk($sformatf("stall%0d", i), tbl[1].exp);
        end
        drive(tbl[3].v, 1'b1); step();
        chk("resume_v3", tbl[2].exp);

        // Mid-stream reset discards in-flight data, even with enable low
        drive(tbl[0].v, 1'b1); step();
        rst_n = 1'b0;
        drive(tbl[1].v, 1'b0);
        step();
        chk("midreset", 64'h0);
        rst_n = 1'b1;
        drive(zero_v, 1'b1); step();
        chk("post_reset_e1", 64'h0);
        drive(tbl[0].v, 1'b1); step();
        chk("post_reset_e2", 64'h0);
        drive(zero_v, 1'b1); step();
        chk("post_reset_v1", tbl[0].exp);

        // Random stream against the latency-tracking model
        rst_n = 1'b0;
        drive(zero_v, 1'b1);
        step();
        rst_n = 1'b1;
        s1 = zero_v;
        o_exp = 64'h0;
        for (int n = 0; n < 10000; n++) begin
            v = mkvec(int'($signed(rnd16())), int'($signed(rnd16())), int'($signed(rnd16())),
                      int'($signed(rnd16())), int'($signed(rnd16())), int'($signed(rnd16())));
            en = ($urandom_range(0, 9) != 0);
            drive(v, en);
            step();
            if (en) begin
                o_exp = model(s1);
                s1 = v;
            end
            chk("rand", o_exp);
        end

        // Cross-check the directed table against the model too
        for (int i = 0; i < 4; i++) begin
            total++;
            if (model(tbl[i].v) === tbl[i].exp) passed++;
            else $display("FAIL model_vec%0d got=%h expected=%h", i + 1, model(tbl[i].v), tbl[i].exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
